dpd_temp_bank_ctrl: RTL and testbench

Slow-domain controller that classifies the PA temperature ADC into COLD/NORMAL/HOT using hysteresis and a dwell filter, with an optional software override. On a confirmed state change it runs a handshake with the weight loader to fill the shadow coefficient bank for the new state. It then issues a single bank-swap pulse to the DPD datapath and freezes adaptation for a settle window. It sits in the clk_1 domain beside the adaptation engine. Its bank_swap and temp_state outputs cross to clk_200 through the existing weight-update CDC.

---
 rtl/dpd_ctrl_pkg.sv | 33 +++
 rtl/temp_hyst_classifier.sv | 98 +++++++++
 rtl/dpd_temp_bank_ctrl.sv | 145 ++++++++++++++
 tb/tb_dpd_temp_bank_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpd_ctrl_pkg.sv
// Shared encodings and default thresholds for the DPD temperature bank controller.
package dpd_ctrl_pkg;

   // Committed / candidate temperature state (same encoding as temp_override).
   typedef enum logic [1:0] {
      TEMP_NORMAL = 2'd0,
      TEMP_COLD   = 2'd1,
      TEMP_HOT    = 2'd2
   } temp_state_e;

   // Bank-swap sequencing FSM.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLoad   = 2'd1,
      StSwap   = 2'd2,
      StSettle = 2'd3
   } ctrl_state_e;

   localparam logic [11:0] DEF_COLD_ENTER = 12'h400;
   localparam logic [11:0] DEF_COLD_EXIT  = 12'h480;
   localparam logic [11:0] DEF_HOT_ENTER  = 12'hC00;
   localparam logic [11:0] DEF_HOT_EXIT   = 12'hB80;

   // Software override code 3 is reserved and falls back to NORMAL.
   function automatic temp_state_e decode_override(input logic [1:0] code);
      case (code)
         2'd1:    return TEMP_COLD;
         2'd2:    return TEMP_HOT;
         default: return TEMP_NORMAL;
      endcase
   endfunction

endpackage

// File: rtl/temp_hyst_classifier.sv
// Hysteresis classifier plus dwell filter: proposes a candidate state and flags
// when a change away from the committed state is confirmed.
module temp_hyst_classifier
   import dpd_ctrl_pkg::*;
#(
   parameter int unsigned          ADC_WIDTH  = 12,
   parameter logic [ADC_WIDTH-1:0] COLD_ENTER = DEF_COLD_ENTER,
   parameter logic [ADC_WIDTH-1:0] COLD_EXIT  = DEF_COLD_EXIT,
   parameter logic [ADC_WIDTH-1:0] HOT_ENTER  = DEF_HOT_ENTER,
   parameter logic [ADC_WIDTH-1:0] HOT_EXIT   = DEF_HOT_EXIT,
   parameter int unsigned          DWELL      = 16
) (
   input  logic                 clk_1,
   input  logic                 rst,
   input  logic [ADC_WIDTH-1:0] temp_adc,
   input  logic                 temp_valid,
   input  logic [1:0]           temp_override,
   input  logic                 temp_override_en,
   input  temp_state_e          temp_state,
   input  logic                 enable,
   output temp_state_e          candidate,
   output logic                 confirm
);

   localparam int unsigned      CNT_W     = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] DWELL_CNT = CNT_W'(DWELL);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   temp_state_e      adc_cand;
   temp_state_e      prev_q, prev_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             sample;
   logic             differs;

   // Threshold comparison relative to the committed state (the hysteresis).
   always_comb begin
      adc_cand = temp_state;
      case (temp_state)
         TEMP_HOT: begin
            if (temp_adc <= COLD_ENTER)    adc_cand = TEMP_COLD;
            else if (temp_adc < HOT_EXIT)  adc_cand = TEMP_NORMAL;
            else                           adc_cand = TEMP_HOT;
         end
         TEMP_COLD: begin
            if (temp_adc >= HOT_ENTER)     adc_cand = TEMP_HOT;
            else if (temp_adc > COLD_EXIT) adc_cand = TEMP_NORMAL;
            else                           adc_cand = TEMP_COLD;
         end
         default: begin
            if (temp_adc >= HOT_ENTER)       adc_cand = TEMP_HOT;
            else if (temp_adc <= COLD_ENTER) adc_cand = TEMP_COLD;
            else                             adc_cand = TEMP_NORMAL;
         end
      endcase
   end

   assign candidate = temp_override_en ? decode_override(temp_override) : adc_cand;
   assign differs   = (candidate != temp_state);
   assign sample    = enable && temp_valid && !temp_override_en;

   // Dwell run-length; held at zero while the controller is busy so that the
   // return to idle starts a fresh evaluation.
   always_comb begin
      dwell_d = dwell_q;
      prev_d  = prev_q;
      if (!enable) begin
         dwell_d = '0;
      end else if (sample) begin
         prev_d = adc_cand;
         if (differs && (adc_cand == prev_q)) begin
            dwell_d = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + CNT_W'(1);
         end else begin
            dwell_d = differs ? CNT_W'(1) : '0;
         end
      end
   end

   // Confirmation uses the updated count so load_req follows the confirming edge.
   always_comb begin
      confirm = 1'b0;
      if (enable) begin
         if (temp_override_en) confirm = differs;
         else                  confirm = sample && differs && (dwell_d >= DWELL_CNT);
      end
   end

   // Dwell state registers.
   always_ff @(posedge clk_1 or posedge rst) begin
      if (rst) begin
         dwell_q <= '0;
         prev_q  <= TEMP_NORMAL;
      end else begin
         dwell_q <= dwell_d;
         prev_q  <= prev_d;
      end
   end

endmodule

// File: rtl/dpd_temp_bank_ctrl.sv
// Temperature-driven coefficient bank controller: classify, load shadow bank,
// swap, then freeze adaptation for a settle window.
module dpd_temp_bank_ctrl
   import dpd_ctrl_pkg::*;
#(
   parameter int unsigned          ADC_WIDTH    = 12,
   parameter logic [ADC_WIDTH-1:0] COLD_ENTER   = DEF_COLD_ENTER,
   parameter logic [ADC_WIDTH-1:0] COLD_EXIT    = DEF_COLD_EXIT,
   parameter logic [ADC_WIDTH-1:0] HOT_ENTER    = DEF_HOT_ENTER,
   parameter logic [ADC_WIDTH-1:0] HOT_EXIT     = DEF_HOT_EXIT,
   parameter int unsigned          DWELL        = 16,
   parameter int unsigned          LOAD_TIMEOUT = 1024,
   parameter int unsigned          SETTLE_CYC   = 8
) (
   input  logic                 clk_1,
   input  logic                 rst,
   input  logic [ADC_WIDTH-1:0] temp_adc,
   input  logic                 temp_valid,
   input  logic [1:0]           temp_override,
   input  logic                 temp_override_en,
   input  logic                 adapt_enable,
   output logic                 load_req,
   output logic [1:0]           load_bank,
   input  logic                 load_done,
   output logic                 bank_swap,
   output logic [1:0]           temp_state,
   output logic                 adapt_active,
   output logic                 busy,
   output logic                 timeout_err,
   input  logic                 err_clr
);

   localparam int unsigned       TO_W        = $clog2(LOAD_TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(LOAD_TIMEOUT - 1);
   localparam int unsigned       SC_W        = $clog2(SETTLE_CYC + 1);
   localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE_CYC - 1);

   ctrl_state_e     state_q, state_d;
   temp_state_e     target_q, target_d;
   temp_state_e     temp_state_q, temp_state_d;
   logic [TO_W-1:0] tcnt_q, tcnt_d;
   logic [SC_W-1:0] scnt_q, scnt_d;
   logic            timeout_err_q, timeout_err_d;
   logic            timeout_set;
   logic            hold;
   temp_state_e     candidate;
   logic            confirm;

   temp_hyst_classifier #(
      .ADC_WIDTH  (ADC_WIDTH),
      .COLD_ENTER (COLD_ENTER),
      .COLD_EXIT  (COLD_EXIT),
      .HOT_ENTER  (HOT_ENTER),
      .HOT_EXIT   (HOT_EXIT),
      .DWELL      (DWELL)
   ) u_classifier (
      .clk_1            (clk_1),
      .rst              (rst),
      .temp_adc         (temp_adc),
      .temp_valid       (temp_valid),
      .temp_override    (temp_override),
      .temp_override_en (temp_override_en),
      .temp_state       (temp_state_q),
      .enable           (state_q == StIdle),
      .candidate        (candidate),
      .confirm          (confirm)
   );

   // Next-state logic for the load/swap/settle sequence and its counters.
   always_comb begin
      state_d      = state_q;
      target_d     = target_q;
      temp_state_d = temp_state_q;
      tcnt_d       = tcnt_q;
      scnt_d       = scnt_q;
      timeout_set  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (confirm) begin
               state_d  = StLoad;
               target_d = candidate;
               tcnt_d   = '0;
            end
         end
         StLoad: begin
            // load_done wins over a timeout in the same cycle.
            if (load_done) begin
               state_d      = StSwap;
               temp_state_d = target_q;
            end else if (tcnt_q == TO_LAST) begin
               state_d     = StIdle;
               timeout_set = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TO_W'(1);
            end
         end
         StSwap: begin
            state_d = StSettle;
            scnt_d  = '0;
         end
         StSettle: begin
            if (scnt_q == SETTLE_LAST) state_d = StIdle;
            else                       scnt_d  = scnt_q + SC_W'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   // Sticky timeout flag; a same-cycle clear beats a new set.
   always_comb begin
      timeout_err_d = timeout_err_q;
      if (err_clr)          timeout_err_d = 1'b0;
      else if (timeout_set) timeout_err_d = 1'b1;
   end

   // State registers.
   always_ff @(posedge clk_1 or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         target_q      <= TEMP_NORMAL;
         temp_state_q  <= TEMP_NORMAL;
         tcnt_q        <= '0;
         scnt_q        <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         temp_state_q  <= temp_state_d;
         tcnt_q        <= tcnt_d;
         scnt_q        <= scnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Outputs decode straight from registers so reset clears them immediately.
   assign hold         = (state_q != StIdle);
   assign busy         = hold;
   assign load_req     = (state_q == StLoad);
   assign load_bank    = target_q;
   assign bank_swap    = (state_q == StSwap);
   assign temp_state   = temp_state_q;
   assign adapt_active = adapt_enable & ~hold;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_dpd_temp_bank_ctrl.sv
// Scoreboard bench for dpd_temp_bank_ctrl with a threshold-rule reference model.
module tb_dpd_temp_bank_ctrl;

   localparam int DWELL        = 16;
   localparam int LOAD_TIMEOUT = 1024;
   localparam int SETTLE_CYC   = 8;
   localparam int COLD_ENTER   = 'h400;
   localparam int COLD_EXIT    = 'h480;
   localparam int HOT_ENTER    = 'hC00;
   localparam int HOT_EXIT     = 'hB80;

   localparam int EV_LOADREQ = 0;
   localparam int EV_SWAP    = 1;
   localparam int EV_TIMEOUT = 2;

   localparam int MODE_TIMEOUT = 0;
   localparam int MODE_SERVE   = 1;
   localparam int MODE_NONE    = 2;

   logic        clk_1 = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] temp_adc = '0;
   logic        temp_valid = 1'b0;
   logic [1:0]  temp_override = '0;
   logic        temp_override_en = 1'b0;
   logic        adapt_enable = 1'b0;
   logic        load_req;
   logic [1:0]  load_bank;
   logic        load_done = 1'b0;
   logic        bank_swap;
   logic [1:0]  temp_state;
   logic        adapt_active;
   logic        busy;
   logic        timeout_err;
   logic        err_clr = 1'b0;

   typedef struct {
      int kind;
      int val;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail = 0;

   // Reference model: committed state, current agreeing-run length, last candidate.
   int   m_state = 0;
   int   m_run = 0;
   int   m_last = 0;
   int   n_rand_timeouts = 0;

   dpd_temp_bank_ctrl u_dut (
      .clk_1            (clk_1),
      .rst              (rst),
      .temp_adc         (temp_adc),
      .temp_valid       (temp_valid),
      .temp_override    (temp_override),
      .temp_override_en (temp_override_en),
      .adapt_enable     (adapt_enable),
      .load_req         (load_req),
      .load_bank        (load_bank),
      .load_done        (load_done),
      .bank_swap        (bank_swap),
      .temp_state       (temp_state),
      .adapt_active     (adapt_active),
      .busy             (busy),
      .timeout_err      (timeout_err),
      .err_clr          (err_clr)
   );

   always #5 clk_1 = ~clk_1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int classify(input int st, input int adc);
      if (st == 0) return (adc >= HOT_ENTER) ? 2 : (adc <= COLD_ENTER) ? 1 : 0;
      if (st == 2) return (adc <= COLD_ENTER) ? 1 : (adc < HOT_EXIT) ? 0 : 2;
      return (adc >= HOT_ENTER) ? 2 : (adc > COLD_EXIT) ? 0 : 1;
   endfunction

   task automatic push_exp(input int kind, input int val);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input string name, input int kind, input int val);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: unexpected event (value %0d), nothing expected", name, val);
      end else begin
         e = sb_q.pop_front();
         check({name, "_kind"}, kind, e.kind);
         check({name, "_val"}, val, e.val);
      end
   endtask

   // Monitor: every visible DUT event must match the next expected entry.
   initial begin
      bit lr_prev = 1'b0;
      bit te_prev = 1'b0;
      forever begin
         @(negedge clk_1);
         if (rst) begin
            lr_prev = 1'b0;
            te_prev = 1'b0;
         end else begin
            if (load_req && !lr_prev) pop_cmp("ev_load_req", EV_LOADREQ, int'(load_bank));
            if (bank_swap)            pop_cmp("ev_bank_swap", EV_SWAP, int'(temp_state));
            if (timeout_err && !te_prev) pop_cmp("ev_timeout", EV_TIMEOUT, 0);
            lr_prev = load_req;
            te_prev = timeout_err;
         end
      end
   end

   // Act as the weight loader once load_req is visible; returns with DUT idle.
   task automatic handle(input int target, input int lat, input int mode);
      int n;
      if (mode == MODE_SERVE) begin
         push_exp(EV_SWAP, target);
         repeat (lat) @(negedge clk_1);
         check("load_req_held", int'(load_req), 1);
         load_done = 1'b1;
         @(negedge clk_1);
         load_done = 1'b0;
         check("swap_latency", int'(bank_swap), 1);
         check("load_req_drop", int'(load_req), 0);
         check("swap_state", int'(temp_state), target);
         check("swap_freeze", int'(adapt_active), 0);
         m_state = target;
         m_run   = 0;
         n = 0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk_1);
            if (!busy) break;
            n++;
         end
         check("settle_len", n, SETTLE_CYC);
         check("adapt_after", int'(adapt_active), int'(adapt_enable));
      end else if (mode == MODE_TIMEOUT) begin
         push_exp(EV_TIMEOUT, 0);
         n = 1;
         for (int i = 0; i < LOAD_TIMEOUT + 100; i++) begin
            @(negedge clk_1);
            if (!load_req) break;
            n++;
         end
         check("timeout_len", n, LOAD_TIMEOUT);
         check("timeout_err_set", int'(timeout_err), 1);
         check("timeout_state", int'(temp_state), m_state);
         check("timeout_idle", int'(busy), 0);
         m_run = 0;
      end
   endtask

   // One temp_valid strobe; checks load_req one cycle after the sampling edge.
   task automatic strobe(input int adc, input int lat, input int mode);
      int  cand;
      bit  fire;
      cand = classify(m_state, adc);
      if (cand != m_state) m_run = (cand == m_last) ? m_run + 1 : 1;
      else                 m_run = 0;
      m_last = cand;
      fire = (m_run >= DWELL);
      if (fire) push_exp(EV_LOADREQ, cand);
      @(negedge clk_1);
      temp_adc   = 12'(adc);
      temp_valid = 1'b1;
      @(negedge clk_1);
      temp_valid = 1'b0;
      check("load_req_latency", int'(load_req), int'(fire));
      if (fire) handle(cand, lat, mode);
   endtask

   task automatic ovr(input int code, input int lat);
      int cand;
      bit fire;
      cand = (code == 1) ? 1 : (code == 2) ? 2 : 0;
      fire = (cand != m_state);
      if (fire) push_exp(EV_LOADREQ, cand);
      @(negedge clk_1);
      temp_override    = 2'(code);
      temp_override_en = 1'b1;
      @(negedge clk_1);
      check("ovr_load_req", int'(load_req), int'(fire));
      if (fire) begin
         handle(cand, lat, MODE_SERVE);
      end else begin
         repeat (3) @(negedge clk_1);
         check("ovr_no_action", int'(busy), 0);
      end
      temp_override_en = 1'b0;
      @(negedge clk_1);
   endtask

   task automatic pulse_err_clr();
      @(negedge clk_1);
      err_clr = 1'b1;
      @(negedge clk_1);
      err_clr = 1'b0;
      check("err_clr", int'(timeout_err), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int band, len, adc, mode;
      int bpts[8];
      bpts = '{'h400, 'h401, 'h480, 'h481, 'hB7F, 'hB80, 'hBFF, 'hC00};

      // 1: reset state and quiet NORMAL input
      repeat (3) @(negedge clk_1);
      check("rst_load_req", int'(load_req), 0);
      rst = 1'b0;
      @(negedge clk_1);
      check("rst_temp_state", int'(temp_state), 0);
      check("rst_load_bank", int'(load_bank), 0);
      check("rst_bank_swap", int'(bank_swap), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_timeout_err", int'(timeout_err), 0);
      check("adapt_off", int'(adapt_active), 0);
      adapt_enable = 1'b1;
      @(negedge clk_1);
      check("adapt_on", int'(adapt_active), 1);
      for (int i = 0; i < 50; i++) strobe('h800, 5, MODE_SERVE);
      check("normal_state", int'(temp_state), 0);

      // 2: hot transition with a 5-cycle loader
      for (int i = 0; i < 16; i++) strobe('hF00, 5, MODE_SERVE);
      check("hot_state", int'(temp_state), 2);

      // 3: chatter around HOT_EXIT never confirms, then go cold
      for (int i = 0; i < 40; i++) strobe((i % 2 == 0) ? 'hB90 : 'hB70, 5, MODE_SERVE);
      check("chatter_state", int'(temp_state), 2);
      for (int i = 0; i < 16; i++) strobe('h100, 3, MODE_SERVE);
      check("cold_state", int'(temp_state), 1);

      // 4: software override
      ovr(0, 2);
      ovr(2, 4);
      ovr(0, 1);
      ovr(3, 1);
      check("ovr_state", int'(temp_state), 0);

      // 5: loader never answers
      for (int i = 0; i < 16; i++) strobe('hF00, 1, MODE_TIMEOUT);
      pulse_err_clr();

      // 6: stray load_done in idle, then reset in the middle of a load
      @(negedge clk_1);
      load_done = 1'b1;
      @(negedge clk_1);
      load_done = 1'b0;
      repeat (2) @(negedge clk_1);
      check("stray_done_idle", int'(busy), 0);
      for (int i = 0; i < 16; i++) strobe('h100, 2, MODE_SERVE);
      for (int i = 0; i < 16; i++) strobe('hF00, 1, MODE_NONE);
      repeat (3) @(negedge clk_1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_load_req", int'(load_req), 0);
      check("rst_async_state", int'(temp_state), 0);
      @(negedge clk_1);
      rst = 1'b0;
      m_state = 0;
      m_run   = 0;
      m_last  = 0;
      @(negedge clk_1);

      // Randomised bursts across every band and the exact threshold values
      for (int b = 0; b < 30; b++) begin
         band = $urandom_range(0, 5);
         len  = $urandom_range(1, 24);
         adapt_enable = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < len; i++) begin
            case (band)
               0: adc = $urandom_range(0, 'h400);
               1: adc = $urandom_range('h401, 'h480);
               2: adc = $urandom_range('h481, 'hB7F);
               3: adc = $urandom_range('hB80, 'hBFF);
               4: adc = $urandom_range('hC00, 'hFFF);
               default: adc = bpts[$urandom_range(0, 7)];
            endcase
            mode = ($urandom_range(0, 19) == 0 && n_rand_timeouts < 2) ?
                   MODE_TIMEOUT : MODE_SERVE;
            if (mode == MODE_TIMEOUT && m_run == DWELL - 1) n_rand_timeouts++;
            strobe(adc, $urandom_range(1, 8), mode);
            if (timeout_err) pulse_err_clr();
            repeat ($urandom_range(0, 2)) @(negedge clk_1);
         end
      end

      repeat (4) @(negedge clk_1);
      check("final_state", int'(temp_state), m_state);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
